// File: rtl/regfile_scan_pkg.sv
// Shared sizing constants and scan FSM state type for the scan-out register file.
package regfile_scan_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } scan_state_e;

endpackage

// File: rtl/regfile_core.sv
// Register storage: one write port, two combinational read ports, one scan read port.
// r0 is hardwired to zero; reads return pre-edge contents (no write bypass).
module regfile_core #(
  parameter int DATA_WIDTH = regfile_scan_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = regfile_scan_pkg::NUM_REGS,
  parameter int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0]     raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic [ADDR_W-1:0]     raddr_s_i,
  output logic [DATA_WIDTH-1:0] rdata_s_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
  assign rdata_s_o = (raddr_s_i == '0) ? '0 : mem_q[raddr_s_i];

endmodule

// File: rtl/regfile_scan.sv
// Register file with a valid/ready dump of r1..r31; 2 cycles per beat, beat held while scan_ready=0.
// Define REGFILE_SCAN_SKIP_ZERO_EN to skip zero-valued registers in the dump.
module regfile_scan #(
  parameter int DATA_WIDTH = regfile_scan_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = regfile_scan_pkg::NUM_REGS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ctrl_writeEnable,
  input  logic [$clog2(NUM_REGS)-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]       data_writeReg,
  input  logic [$clog2(NUM_REGS)-1:0] ctrl_readRegA,
  input  logic [$clog2(NUM_REGS)-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0]       data_readRegA,
  output logic [DATA_WIDTH-1:0]       data_readRegB,
  input  logic                        scan_start,
  output logic                        scan_valid,
  input  logic                        scan_ready,
  output logic [$clog2(NUM_REGS)-1:0] scan_addr,
  output logic [DATA_WIDTH-1:0]       scan_data,
  output logic                        scan_busy,
  output logic                        scan_done
);

  import regfile_scan_pkg::*;

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  scan_state_e           state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] fetch_dat;

  regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_W     (AW)
  ) u_core (
    .clk_i     (clock),
    .rst_ni    (reset),
    .we_i      (ctrl_writeEnable),
    .waddr_i   (ctrl_writeReg),
    .wdata_i   (data_writeReg),
    .raddr_a_i (ctrl_readRegA),
    .rdata_a_o (data_readRegA),
    .raddr_b_i (ctrl_readRegB),
    .rdata_b_o (data_readRegB),
    .raddr_s_i (ptr_q),
    .rdata_s_o (fetch_dat)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = FETCH;
          ptr_d   = AW'(1);
        end
      end
      FETCH: begin
`ifdef REGFILE_SCAN_SKIP_ZERO_EN
        if (fetch_dat == '0) begin
          state_d = (ptr_q == LAST) ? DONE : FETCH;
          ptr_d   = ptr_q + AW'(1);
        end else begin
          addr_d  = ptr_q;
          data_d  = fetch_dat;
          state_d = SEND;
        end
`else
        addr_d  = ptr_q;
        data_d  = fetch_dat;
        state_d = SEND;
`endif
      end
      SEND: begin
        // Snapshot in data_q keeps the beat stable even if the source register is rewritten.
        if (scan_ready) begin
          state_d = (ptr_q == LAST) ? DONE : FETCH;
          ptr_d   = ptr_q + AW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign scan_valid = (state_q == SEND);
  assign scan_busy  = (state_q != IDLE);
  assign scan_done  = (state_q == DONE);
  assign scan_addr  = addr_q;
  assign scan_data  = data_q;

endmodule

// File: tb/tb_regfile_scan.sv
// Self-checking bench for regfile_scan: read/write vectors, random traffic vs an array model,
// and scan-out sequences (full dump, restart ignore, stall hold, mid-scan reset, zero skip).
module tb_regfile_scan;

`ifdef REGFILE_SCAN_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic        scan_start, scan_valid, scan_ready, scan_busy, scan_done;
  logic [4:0]  scan_addr;
  logic [31:0] scan_data;

  regfile_scan dut (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .scan_start       (scan_start),
    .scan_valid       (scan_valid),
    .scan_ready       (scan_ready),
    .scan_addr        (scan_addr),
    .scan_data        (scan_data),
    .scan_busy        (scan_busy),
    .scan_done        (scan_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = -1;
  int          done_cnt = 0;
  int          exp_cycles = 0;
  logic [31:0] model [32];
  logic [4:0]  beat_a [$];
  logic [31:0] beat_d [$];
  logic [4:0]  exp_a [$];
  logic [31:0] exp_d [$];
  logic        hold_vld = 1'b0;
  logic [4:0]  hold_addr = '0;
  logic [31:0] hold_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // One clock: observe the stream at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clock);
    if (hold_vld && scan_valid) begin
      chk("hold_addr", 32'(scan_addr), 32'(hold_addr));
      chk("hold_data", scan_data, hold_data);
    end
    if (scan_valid && scan_ready) begin
      beat_a.push_back(scan_addr);
      beat_d.push_back(scan_data);
    end
    if (scan_done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    hold_vld  = scan_valid && !scan_ready;
    hold_addr = scan_addr;
    hold_data = scan_data;
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = a;
    data_writeReg    = d;
    tick();
    ctrl_writeEnable = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic start_scan();
    exp_a.delete();
    exp_d.delete();
    exp_cycles = 0;
    for (int r = 1; r < 32; r++) begin
      if (!SKIP || model[r] != 32'd0) begin
        exp_a.push_back(5'(r));
        exp_d.push_back(model[r]);
        exp_cycles += 2;
      end else begin
        exp_cycles += 1;
      end
    end
    beat_a.delete();
    beat_d.delete();
    done_cnt = 0;
    done_cyc = -1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no scan_done required=scan_done within 200 cycles", tag);
    end
    repeat (4) tick();
  endtask

  task automatic check_scan(input string tag, input bit check_time);
    chk({tag, "_beats"}, beat_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < beat_a.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(beat_a[i]), 32'(exp_a[i]));
      chk($sformatf("%s_data%0d", tag, i), beat_d[i], exp_d[i]);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_after"}, 32'(scan_busy), 32'd0);
    if (check_time) chk({tag, "_done_time"}, done_cyc - start_cyc, exp_cycles);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'h0000_00AA, 5'd5,  5'd0,  32'h0,          32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd5,  5'd0,  32'h0000_00AA, 32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0,          32'h0000_00AA};
    vecs[3] = '{1'b1, 5'd31, 32'hCAFE_BABE, 5'd31, 5'd1,  32'h0,          32'h0};
    vecs[4] = '{1'b1, 5'd1,  32'h1111_1111, 5'd31, 5'd5,  32'hCAFE_BABE, 32'h0000_00AA};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd31, 32'h1111_1111, 32'hCAFE_BABE};

    for (int r = 0; r < 32; r++) model[r] = 32'd0;
    reset = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg = '0;
    data_writeReg = '0;
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd31;
    scan_start = 1'b0;
    scan_ready = 1'b1;

    #12;
    chk("rst_valid", 32'(scan_valid), 32'd0);
    chk("rst_busy",  32'(scan_busy),  32'd0);
    chk("rst_done",  32'(scan_done),  32'd0);
    chk("rst_addr",  32'(scan_addr),  32'd0);
    chk("rst_data",  scan_data,       32'd0);
    chk("rst_rdA",   data_readRegA,   32'd0);
    chk("rst_rdB",   data_readRegB,   32'd0);
    #10;
    reset = 1'b1;
    tick();

    // Directed read/write vectors; each read is taken before that cycle's write lands.
    for (int i = 0; i < 6; i++) begin
      ctrl_writeEnable = vecs[i].we;
      ctrl_writeReg    = vecs[i].wr;
      data_writeReg    = vecs[i].wd;
      ctrl_readRegA    = vecs[i].ra;
      ctrl_readRegB    = vecs[i].rb;
      #1;
      chk($sformatf("vec%0d_A", i), data_readRegA, vecs[i].ea);
      chk($sformatf("vec%0d_B", i), data_readRegB, vecs[i].eb);
      tick();
      if (vecs[i].we && vecs[i].wr != 5'd0) model[vecs[i].wr] = vecs[i].wd;
    end
    ctrl_writeEnable = 1'b0;

    for (int i = 0; i < 200; i++) begin
      ctrl_writeEnable = 1'($urandom_range(0, 1));
      ctrl_writeReg    = 5'($urandom_range(0, 31));
      data_writeReg    = $urandom();
      ctrl_readRegA    = 5'($urandom_range(0, 31));
      ctrl_readRegB    = 5'($urandom_range(0, 31));
      #1;
      chk($sformatf("rnd%0d_A", i), data_readRegA, model[ctrl_readRegA]);
      chk($sformatf("rnd%0d_B", i), data_readRegB, model[ctrl_readRegB]);
      tick();
      if (ctrl_writeEnable && ctrl_writeReg != 5'd0) model[ctrl_writeReg] = data_writeReg;
    end
    ctrl_writeEnable = 1'b0;

    // Full dump with scan_ready held high.
    wr(5'd3, 32'h1234_5678);
    scan_ready = 1'b1;
    start_scan();
    chk("lat_busy_n1",  32'(scan_busy),  32'd1);
    chk("lat_valid_n1", 32'(scan_valid), 32'd0);
    tick();
    if (exp_a.size() > 0) begin
      chk("lat_valid_n2", 32'(scan_valid), 32'd1);
      chk("lat_addr_n2",  32'(scan_addr),  32'(exp_a[0]));
    end
    wait_done("full");
    check_scan("full", 1'b1);

    // Extra scan_start pulses while busy are ignored.
    start_scan();
    repeat (5) tick();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (20) tick();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    wait_done("restart");
    check_scan("restart", 1'b1);

    // Stall on r3's beat while r3 is rewritten.
    start_scan();
    begin
      int n = 0;
      while (!(scan_valid && scan_addr == 5'd3) && n < 100) begin
        tick();
        n++;
      end
      chk("stall_reach_r3", 32'(scan_valid && scan_addr == 5'd3), 32'd1);
    end
    scan_ready = 1'b0;
    wr(5'd3, 32'h0000_DEAD);
    repeat (9) tick();
    chk("stall_valid", 32'(scan_valid), 32'd1);
    chk("stall_addr",  32'(scan_addr),  32'd3);
    chk("stall_data",  scan_data,       32'h1234_5678);
    scan_ready = 1'b1;
    wait_done("stall");
    check_scan("stall", 1'b0);
    start_scan();
    wait_done("rescan");
    check_scan("rescan", 1'b1);

    // Reset while holding the beat for r12.
    wr(5'd12, 32'h0000_0012);
    start_scan();
    begin
      int n = 0;
      while (!(scan_valid && scan_addr == 5'd12) && n < 100) begin
        tick();
        n++;
      end
      chk("mid_reach_r12", 32'(scan_valid && scan_addr == 5'd12), 32'd1);
    end
    scan_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_valid", 32'(scan_valid), 32'd0);
    chk("mid_busy",  32'(scan_busy),  32'd0);
    chk("mid_done",  32'(scan_done),  32'd0);
    chk("mid_addr",  32'(scan_addr),  32'd0);
    chk("mid_data",  scan_data,       32'd0);
    ctrl_readRegA = 5'd12;
    ctrl_readRegB = 5'd3;
    #1;
    chk("mid_rd12", data_readRegA, 32'd0);
    chk("mid_rd3",  data_readRegB, 32'd0);
    for (int r = 0; r < 32; r++) model[r] = 32'd0;
    beat_a.delete();
    beat_d.delete();
    done_cnt = 0;
    repeat (3) tick();
    reset = 1'b1;
    scan_ready = 1'b1;
    repeat (70) tick();
    chk("post_rst_beats", beat_a.size(), 0);
    chk("post_rst_done",  done_cnt, 0);
    chk("post_rst_busy",  32'(scan_busy), 32'd0);

    // Sparse contents: only r7 and r30 nonzero.
    wr(5'd7, 32'h0000_0007);
    wr(5'd30, 32'h0000_001E);
    start_scan();
    wait_done("sparse");
    check_scan("sparse", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
